// File: rtl/id_ex_stage.sv
// ID-stage operand selection, branch resolution and load-use bubble insertion,
// followed by the ID/EX pipeline register and a saturating stall counter.
module id_ex_stage #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic              uses_rs,
   input  logic              uses_rt,
   input  logic [WIDTH-1:0]  rf_a,
   input  logic [WIDTH-1:0]  rf_b,
   input  logic [1:0]        fwd_a,
   input  logic [1:0]        fwd_b,
   input  logic [WIDTH-1:0]  ex_aluout,
   input  logic [WIDTH-1:0]  mem_aluout,
   input  logic [WIDTH-1:0]  mem_data_in,
   input  logic [4:0]        ex_back,
   input  logic              ex_MemRead,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [WIDTH-1:0]  id_imm,
   input  logic [4:0]        id_back,
   input  logic              is_branch,
   input  logic              branch_ne,
   output logic              stall,
   output logic              branch_taken,
   output logic              flush_ifid,
   output logic              ex_valid,
   output logic [WIDTH-1:0]  ex_a,
   output logic [WIDTH-1:0]  ex_b,
   output logic [WIDTH-1:0]  ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_wb,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             hz;
   logic             eq;

   // $zero is never a forwarding target, so index 0 always reads the register file.
   always_comb begin
      case (fwd_a)
         2'd0:    op_a = rf_a;
         2'd1:    op_a = ex_aluout;
         2'd2:    op_a = mem_aluout;
         default: op_a = mem_data_in;
      endcase
      if (rs == 5'd0) op_a = rf_a;
   end

   always_comb begin
      case (fwd_b)
         2'd0:    op_b = rf_b;
         2'd1:    op_b = ex_aluout;
         2'd2:    op_b = mem_aluout;
         default: op_b = mem_data_in;
      endcase
      if (rt == 5'd0) op_b = rf_b;
   end

   always_comb begin
      hz = id_valid & ex_MemRead & (ex_back != 5'd0) &
           ((uses_rs & (rs == ex_back)) | (uses_rt & (rt == ex_back)));
      stall        = hz;
      eq           = (op_a == op_b);
      branch_taken = id_valid & is_branch & ~hz & (eq ^ branch_ne);
      flush_ifid   = branch_taken;
   end

   // A stall loads an all-zero bubble; the branch itself still proceeds into EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_imm   <= '0;
         ex_ctrl  <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_wb    <= '0;
      end else if (hz) begin
         ex_valid <= 1'b0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_imm   <= '0;
         ex_ctrl  <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_wb    <= '0;
      end else begin
         ex_valid <= id_valid;
         ex_a     <= op_a;
         ex_b     <= op_b;
         ex_imm   <= id_imm;
         ex_ctrl  <= id_valid ? id_ctrl : '0;
         ex_rs    <= rs;
         ex_rt    <= rt;
         ex_wb    <= id_back;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (hz && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-side operand stage and ID/EX pipeline register of the five-stage MIPS core. It consumes the 2-bit forwarding selects produced by the ID-stage forwarding unit and builds the final rs/rt operands from the register file, EX ALU result, MEM ALU result or MEM load data. It resolves beq/bne in ID, detects the one load-use case forwarding cannot cover, and inserts a bubble. It then registers operands and control into EX.

## Interface
- WIDTH, 32, datapath width
- CTRL_W, 12, width of opaque EX/MEM/WB control bundle
- CNT_W, 16, width of stall performance counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- rs, rt  in  5  source register indices
- uses_rs, uses_rt  in  1  instruction actually reads rs / rt
- rf_a, rf_b  in  WIDTH  register file read data
- fwd_a, fwd_b  in  2  forward select: 0 rf, 1 ex_aluout, 2 mem_aluout, 3 mem_data_in
- ex_aluout, mem_aluout, mem_data_in  in  WIDTH  forwarding sources
- ex_back  in  5  destination of instruction now in EX
- ex_MemRead  in  1  instruction in EX is a load
- id_ctrl  in  CTRL_W  decoded control bundle
- id_imm  in  WIDTH  sign/zero-extended immediate
- id_back  in  5  destination register of ID instruction
- is_branch, branch_ne  in  1  beq/bne decode
- stall  out  1  hold PC and IF/ID (combinational)
- branch_taken  out  1  redirect PC to branch target (combinational)
- flush_ifid  out  1  clear IF/ID next edge (combinational)
- ex_valid  out  1  registered valid
- ex_a, ex_b, ex_imm  out  WIDTH  registered operands/immediate
- ex_ctrl  out  CTRL_W  registered control
- ex_rs, ex_rt, ex_wb  out  5  registered indices/destination
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Operand mux: opA = select(fwd_a), opB = select(fwd_b). Index 0 overrides the select: if rs==0, opA = rf_a; if rt==0, opB = rf_b. Forwarding never targets $zero.
- Load-use hazard: hz = id_valid & ex_MemRead & ex_back!=0 & ((uses_rs & rs==ex_back) | (uses_rt & rt==ex_back)).
- stall = hz. While stall is high, the register loads a bubble: ex_valid=0, ex_ctrl=0, ex_wb=0. ex_a, ex_b, ex_imm, ex_rs and ex_rt are don't-care but set to 0.
- After one stall cycle, the load is in MEM and the forwarding unit supplies select 3. A single stall always suffices, because the bubble has ex_MemRead=0.
- Branch: eq = (opA==opB). branch_taken = id_valid & is_branch & ~stall & (eq ^ branch_ne). flush_ifid = branch_taken.
- The branch itself still enters EX as a normal instruction.
- When not stalled, the register loads id_valid, opA, opB, id_imm, id_ctrl, rs, rt and id_back. If id_valid=0, ex_ctrl is forced to 0.
- stall_cnt increments on every clock with stall=1 and saturates at all-ones.

## Timing
- Reset (asynchronous, rst_n=0): all ex_* = 0, ex_valid = 0, stall_cnt = 0. Combinational outputs follow their inputs.
- Latency: ID values appear on ex_* one clk edge after capture.
- stall, branch_taken and flush_ifid are same-cycle combinational. Upstream samples them on the same edge.
- stall and branch_taken are mutually exclusive by construction. A stalled branch re-evaluates next cycle with forwarded load data.
- Reset deasserted mid-stall: the first post-reset cycle re-evaluates hz from the current inputs. No state is held across reset.

## Test plan
- Reset: assert rst_n=0 mid-run with ex_valid=1 -> all ex_* = 0 and stall_cnt=0 immediately, without waiting for clk.
- Forward select: rs=5, rf_a=1, ex_aluout=2, mem_aluout=3, mem_data_in=4, fwd_a stepped 0..3 -> ex_a = 1, 2, 3, 4 on successive edges. Repeat with rs=0 -> ex_a=1 for every select.
- Load-use: ex_MemRead=1, ex_back=8, rt=8, uses_rt=1 -> stall=1 and the next edge gives ex_valid=0, ex_ctrl=0. The next cycle with ex_MemRead=0 and fwd_b=3 gives ex_b=mem_data_in and stall_cnt=1.
- Non-use: same as load-use but uses_rt=0, or ex_back=0 -> stall=0 and the instruction passes.
- Branch: beq with opA=opB=0x10 -> branch_taken=1 and flush_ifid=1. bne with the same operands -> 0. beq dependent on a load in EX -> stall=1 and branch_taken=0; next cycle with fwd=3 and equal data -> branch_taken=1.
- Counter: hold hz true for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cnt saturates at 15.
